// File: rtl/mips_pkg.sv
// ============================================================================
//  mips_pkg
//  Shared types and encodings for the multi-cycle MIPS control unit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_SUBU,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_ILL
  } instr_cls_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;

  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_subu  = 6'b100011;

  localparam logic [1:0] c_alu_add  = 2'b00;
  localparam logic [1:0] c_alu_sub  = 2'b01;
  localparam logic [1:0] c_alu_or   = 2'b10;
  localparam logic [1:0] c_alu_passb = 2'b11;

  localparam logic [1:0] c_ext_zero = 2'b00;
  localparam logic [1:0] c_ext_sign = 2'b01;
  localparam logic [1:0] c_ext_lui  = 2'b10;

  localparam logic [1:0] c_npc_pc4  = 2'b00;
  localparam logic [1:0] c_npc_br   = 2'b01;
  localparam logic [1:0] c_npc_jmp  = 2'b10;

  localparam logic [1:0] c_dst_rt   = 2'b00;
  localparam logic [1:0] c_dst_rd   = 2'b01;
  localparam logic [1:0] c_dst_ra   = 2'b10;

  localparam logic [1:0] c_wb_alu   = 2'b00;
  localparam logic [1:0] c_wb_mem   = 2'b01;
  localparam logic [1:0] c_wb_pc4   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_mc_decode.sv
// ============================================================================
//  mips_mc_decode
//  Maps opcode/funct to an instruction class; jal decodes only when
//  MIPS_JAL_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_t cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      c_op_rtype: begin
        case (funct)
          c_fn_addu: cls = CLS_ADDU;
          c_fn_subu: cls = CLS_SUBU;
          default:   cls = CLS_ILL;
        endcase
      end
      c_op_ori:  cls = CLS_ORI;
      c_op_lui:  cls = CLS_LUI;
      c_op_lw:   cls = CLS_LW;
      c_op_sw:   cls = CLS_SW;
      c_op_beq:  cls = CLS_BEQ;
      c_op_j:    cls = CLS_J;
`ifdef MIPS_JAL_EN
      c_op_jal:  cls = CLS_JAL;
`else
      c_op_jal:  cls = CLS_ILL;
`endif
      default:   cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
//  mips_mc_ctrl
//  Multi-cycle MIPS control FSM with memory req/ready handshake and wait
//  timeout. Optional jal support via MIPS_JAL_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemWr,
  output logic        IRWr,
  output logic        PCWr,
  output logic [1:0]  nPC_sel,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ExtOp,
  output logic [1:0]  ALUctr,
  output logic [2:0]  state,
  output logic        err
);

  // A disabled timeout (MEM_TIMEOUT=0) would give a zero-width counter.
  localparam int c_cw = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [c_cw-1:0] c_lim = (MEM_TIMEOUT > 0) ? c_cw'(MEM_TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [c_cw-1:0] r_cnt;
  logic            r_err;
  logic            w_set_err;
  logic            w_timeout;
  instr_cls_t      w_cls;
  logic            w_illegal;
  logic            w_req, w_memwr, w_irwr, w_pcwr, w_regwr;
  logic            w_alu_src;
  logic [1:0]      w_ext, w_alu;
  logic            w_unused_bits;

  mips_mc_decode u_decode (
    .opcode  (instruction[31:26]),
    .funct   (instruction[5:0]),
    .cls     (w_cls),
    .illegal (w_illegal)
  );

  assign w_unused_bits = ^instruction[25:6];

  // This is the MEM_TIMEOUT-th consecutive wait cycle with no ready.
  assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready && (r_cnt == c_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_err | w_set_err;
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_alu_src = 1'b0;
    w_ext     = c_ext_zero;
    w_alu     = c_alu_add;
    case (w_cls)
      CLS_SUBU: w_alu = c_alu_sub;
      CLS_ORI: begin
        w_alu_src = 1'b1;
        w_alu     = c_alu_or;
      end
      CLS_LUI: begin
        w_alu_src = 1'b1;
        w_ext     = c_ext_lui;
        w_alu     = c_alu_passb;
      end
      CLS_LW, CLS_SW: begin
        w_alu_src = 1'b1;
        w_ext     = c_ext_sign;
      end
      CLS_BEQ: w_alu = c_alu_sub;
      default: w_alu = c_alu_add;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_req     = 1'b0;
    w_memwr   = 1'b0;
    w_irwr    = 1'b0;
    w_pcwr    = 1'b0;
    w_regwr   = 1'b0;
    IorD      = 1'b0;
    nPC_sel   = c_npc_pc4;
    RegDst    = c_dst_rt;
    MemtoReg  = c_wb_alu;
    ALUSrc    = 1'b0;
    ExtOp     = c_ext_zero;
    ALUctr    = c_alu_add;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = ST_DECODE;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (w_illegal) begin
          w_set_err = 1'b1;
          w_next    = ST_HALT;
        end else if (w_cls == CLS_J) begin
          w_pcwr  = 1'b1;
          nPC_sel = c_npc_jmp;
          w_next  = ST_FETCH;
`ifdef MIPS_JAL_EN
        end else if (w_cls == CLS_JAL) begin
          w_pcwr  = 1'b1;
          nPC_sel = c_npc_jmp;
          w_next  = ST_WB;
`endif
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALUSrc = w_alu_src;
        ExtOp  = w_ext;
        ALUctr = w_alu;
        case (w_cls)
          CLS_LW, CLS_SW: w_next = ST_MEM;
          CLS_BEQ: begin
            w_pcwr  = zero;
            nPC_sel = c_npc_br;
            w_next  = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_req   = 1'b1;
        IorD    = 1'b1;
        w_memwr = (w_cls == CLS_SW);
        if (mem_ready) begin
          w_next = (w_cls == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = ST_HALT;
        end
      end
      ST_WB: begin
        w_regwr = 1'b1;
        w_next  = ST_FETCH;
        // ALU controls are held so the result stays valid during the write.
        case (w_cls)
          CLS_ADDU, CLS_SUBU: begin
            RegDst = c_dst_rd;
            ALUctr = w_alu;
          end
          CLS_ORI, CLS_LUI: begin
            ALUSrc = w_alu_src;
            ExtOp  = w_ext;
            ALUctr = w_alu;
          end
          CLS_LW: MemtoReg = c_wb_mem;
`ifdef MIPS_JAL_EN
          CLS_JAL: begin
            RegDst   = c_dst_ra;
            MemtoReg = c_wb_pc4;
          end
`endif
          default: RegDst = c_dst_rt;
        endcase
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // Strobes are masked by rst so nothing fires in a reset cycle.
  assign mem_req = w_req   & ~rst;
  assign MemWr   = w_memwr & ~rst;
  assign IRWr    = w_irwr  & ~rst;
  assign PCWr    = w_pcwr  & ~rst;
  assign RegWr   = w_regwr & ~rst;
  assign state   = r_state;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. It replaces the single-cycle decoder with an FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It talks to a shared instruction/data memory through a req/ready handshake with a parametrised timeout. It sits beside `mips_dp`: it reads the latched instruction and the ALU zero flag, and drives every datapath strobe and mux select.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles on a memory access before the unit halts. A value of 0 disables the timeout.
- `CNT_W`, default `$clog2(MEM_TIMEOUT+1)`: width of the wait counter. Derived; not overridden.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instruction` in 32: IR contents from the datapath.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `IorD` out 1: address select; 0 = PC, 1 = ALU result.
- `MemWr` out 1: write strobe, qualified by `mem_req`.
- `IRWr` out 1: latch the instruction register.
- `PCWr` out 1: update the PC.
- `nPC_sel` out 2: next-PC source; 00 = PC+4, 01 = branch target, 10 = jump target.
- `RegWr` out 1: register file write.
- `RegDst` out 2: destination register; 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` out 2: write-back source; 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUSrc` out 1: ALU B operand; 0 = register, 1 = extended immediate.
- `ExtOp` out 2: immediate extension; 00 = zero-extend, 01 = sign-extend, 10 = load upper.
- `ALUctr` out 2: ALU function; 00 = add, 01 = sub, 10 = or, 11 = pass B.
- `state` out 3: current FSM state, for debug.
- `err` out 1: sticky flag for an illegal instruction or a memory timeout.

## Operation
- Supported instructions:
  - addu: opcode 000000, funct 100001.
  - subu: opcode 000000, funct 100011.
  - ori: opcode 001101.
  - lui: opcode 001111.
  - lw: opcode 100011.
  - sw: opcode 101011.
  - beq: opcode 000100.
  - j: opcode 000010.
  - jal: opcode 000011, only when `MIPS_JAL_EN` is defined.
- States and their encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - Drives `mem_req`=1 and `IorD`=0.
  - On `mem_ready`: assert `IRWr`, `PCWr` and `nPC_sel`=00, then go to DECODE.
- DECODE:
  - j: assert `PCWr` with `nPC_sel`=10, then go to FETCH.
  - Illegal opcode or funct: set `err`, then go to HALT.
  - Any other instruction: go to EXEC.
- EXEC:
  - R-type, ori and lui: drive the ALU controls, then go to WB.
  - lw and sw: compute the address (`ALUSrc`=1, `ExtOp`=01, `ALUctr`=00), then go to MEM.
  - beq: drive `ALUctr`=01, `PCWr`=`zero`, `nPC_sel`=01, then go to FETCH.
- MEM:
  - Drives `mem_req`=1 and `IorD`=1.
  - Drives `MemWr`=1 for sw.
  - On `mem_ready`: lw goes to WB; sw goes to FETCH.
- WB:
  - Asserts `RegWr`=1 for exactly one cycle, then goes to FETCH.
  - R-type: `RegDst`=01. lw: `MemtoReg`=01. ori/lui: `RegDst`=00, `ExtOp`=00 or 10.
- HALT: all strobes stay 0. The unit leaves HALT only on `rst`.
- Outputs are combinational from `state`, the decoded instruction, `mem_ready` and `zero`. All unused selects are 00.

## Timing
- Reset value of every output:
  - `state`=FETCH, `err`=0, wait counter=0.
  - All strobes (`mem_req`, `MemWr`, `IRWr`, `PCWr`, `RegWr`) are forced to 0 while `rst` is high.
  - All selects are 00.
- The first `mem_req` is asserted in the first cycle after `rst` deasserts.
- Asserting reset mid-instruction aborts it immediately; no strobe fires in the reset cycle.
- Cycles per instruction with zero-wait memory:
  - j: 2.
  - beq: 3.
  - R-type, ori, lui, sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Increments on every FETCH or MEM cycle in which `mem_ready`=0.
  - Clears on every state change.
  - Reaching `MEM_TIMEOUT` while `mem_ready` is low sets `err` and moves the FSM to HALT on the next edge.
  - If `mem_ready` arrives in the same cycle the counter hits the limit, `mem_ready` wins and the access completes normally.
- `mem_req` stays high and `IorD` stays stable until `mem_ready` is seen.
- `err` stays set until reset.

## Configuration
- `MIPS_JAL_EN` defined:
  - jal is decoded and takes DECODE → WB.
  - In DECODE it asserts `PCWr` with `nPC_sel`=10.
  - In WB it writes PC+4 to $31 (`RegDst`=10, `MemtoReg`=10).
  - CPI for jal is 3.
- `MIPS_JAL_EN` undefined: opcode 000011 is treated as illegal (`err` set, FSM to HALT). The 10 encodings of `RegDst` and `MemtoReg` are never driven.

## Structure
- Package `mips_pkg` holds:
  - The state enum.
  - Opcode and funct constants.
  - The `ALUctr`, `ExtOp`, `nPC_sel`, `RegDst` and `MemtoReg` encodings.
  - The instruction-class enum.
- Sub-module `mips_mc_decode`: combinational mapping from opcode and funct to instruction class plus an illegal flag. The FSM and the wait counter live in `mips_mc_ctrl`.

## Test plan
- Reset: `rst` pulsed mid-EXEC → next cycle `state`=0, `err`=0, all strobes 0; after release, `mem_req`=1.
- addu then lw with `mem_ready` tied to 1 → addu takes 4 cycles with one `RegWr` pulse (`RegDst`=01); lw takes 5 cycles (`MemtoReg`=01).
- beq with `zero`=1 versus `zero`=0 → in EXEC, `PCWr` is 1 versus 0; both instructions return to FETCH after 3 cycles.
- `MEM_TIMEOUT`=4 with `mem_ready` held low in FETCH → after 4 wait cycles `state`=5 and `err`=1, and `mem_req` stays 0 afterwards.
- `mem_ready` rising in exactly the 4th wait cycle → the access completes, `err`=0.
- Opcode 000011 → with the macro defined, $31 is written via `RegDst`=10 in 3 cycles; without it, the FSM goes to HALT with `err`=1.
